// File: rtl/hilo_div_ctrl.sv
// hilo_div_ctrl: sequences the multi-cycle divider for DIV/DIVU and owns the architectural HI/LO registers
module hilo_div_ctrl (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ex_valid,
  input  logic [2:0]  ex_op,
  input  logic [31:0] ex_src1,
  input  logic [31:0] ex_src2,
  input  logic        ex_cancel,
  output logic        ex_stall,
  output logic        div_begin,
  output logic        div_sign,
  output logic [31:0] div_op1,
  output logic [31:0] div_op2,
  input  logic [31:0] div_result,
  input  logic [31:0] div_remainder,
  input  logic        div_end,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t r_state, w_next;
  logic r_begin, r_sign;
  logic [31:0] r_op1, r_op2, r_hi, r_lo;
  logic w_is_div, w_accept, w_mt;
  assign w_is_div = ex_valid & (ex_op == 3'b001 | ex_op == 3'b010);
  assign w_accept = (r_state == IDLE) & w_is_div & ~ex_cancel;
  assign w_mt = (r_state == IDLE) & ex_valid & ~ex_cancel;
  // the dividing instruction leaves EX only in the DONE cycle
  assign ex_stall = w_is_div & (r_state != DONE);
  assign div_begin = r_begin;
  assign div_sign = r_sign;
  assign div_op1 = r_op1;
  assign div_op2 = r_op2;
  assign hi_out = r_hi;
  assign lo_out = r_lo;
  always_comb begin
    w_next = IDLE;
    if (r_state == IDLE) w_next = w_accept ? BUSY : IDLE;
    else if (r_state == BUSY) w_next = ex_cancel ? IDLE : (div_end ? DONE : BUSY);
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= IDLE;
      r_begin <= 1'b0;
      r_sign <= 1'b0;
      r_op1 <= '0;
      r_op2 <= '0;
      r_hi <= '0;
      r_lo <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_begin <= 1'b1;
        r_sign <= (ex_op == 3'b001);
        r_op1 <= ex_src1;
        r_op2 <= ex_src2;
      end
      if (r_state == BUSY && (ex_cancel || div_end)) r_begin <= 1'b0;
      if (w_mt && ex_op == 3'b011) r_hi <= ex_src1;
      if (w_mt && ex_op == 3'b100) r_lo <= ex_src1;
      if (r_state == DONE && !ex_cancel) begin
        r_lo <= div_result;
        r_hi <= div_remainder;
      end
    end
  end
endmodule

// File: tb/tb_hilo_div_ctrl.sv
// tb_hilo_div_ctrl: divider stub plus transaction-level HI/LO model, checked every cycle
module tb_hilo_div_ctrl;
  logic clk = 0, resetn = 0, ex_valid = 0, ex_cancel = 0, div_end;
  logic [2:0] ex_op = 0;
  logic [31:0] ex_src1 = 0, ex_src2 = 0, div_result, div_remainder;
  logic ex_stall, div_begin, div_sign;
  logic [31:0] div_op1, div_op2, hi_out, lo_out;
  int n_chk = 0, n_fail = 0;
  int lat = 36, cnt = 0, n;
  logic spur = 0, chk_en = 0, hold;

  always #5 clk = ~clk;

  hilo_div_ctrl dut (
    .clk(clk), .resetn(resetn), .ex_valid(ex_valid), .ex_op(ex_op),
    .ex_src1(ex_src1), .ex_src2(ex_src2), .ex_cancel(ex_cancel),
    .ex_stall(ex_stall), .div_begin(div_begin), .div_sign(div_sign),
    .div_op1(div_op1), .div_op2(div_op2), .div_result(div_result),
    .div_remainder(div_remainder), .div_end(div_end),
    .hi_out(hi_out), .lo_out(lo_out)
  );

  // {remainder, quotient} with MIPS truncating semantics; /0 and overflow give fixed junk
  function automatic logic [63:0] ref_div(logic s, logic [31:0] a, logic [31:0] b);
    if (b == 0) return {a, 32'hFFFFFFFF};
    if (s && a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'h0, a};
    if (s) return {32'($signed(a) % $signed(b)), 32'($signed(a) / $signed(b))};
    return {a % b, a / b};
  endfunction

  // divider stub: completes lat cycles after div_begin rises; spur injects stray pulses
  always @(posedge clk) cnt <= div_begin ? cnt + 1 : 0;
  assign div_end = (div_begin && cnt == lat - 1) || spur;
  assign {div_remainder, div_result} = ref_div(div_sign, div_op1, div_op2);

  logic [31:0] m_hi = 0, m_lo = 0, m_op1 = 0, m_op2 = 0;
  logic m_sign = 0, m_pend = 0, m_end = 0;
  wire is_div = ex_valid && (ex_op == 3'd1 || ex_op == 3'd2);

  always @(posedge clk) begin
    if (!resetn) begin
      m_hi = 0; m_lo = 0; m_op1 = 0; m_op2 = 0; m_sign = 0; m_pend = 0; m_end = 0;
    end else if (m_end) begin
      if (!ex_cancel) {m_hi, m_lo} = ref_div(m_sign, m_op1, m_op2);
      m_end = 0; m_pend = 0;
    end else if (m_pend) begin
      if (ex_cancel) m_pend = 0;
      else if (div_end) m_end = 1;
    end else if (!ex_cancel && is_div) begin
      m_pend = 1; m_op1 = ex_src1; m_op2 = ex_src2; m_sign = (ex_op == 3'd1);
    end else if (!ex_cancel && ex_valid && ex_op == 3'd3) m_hi = ex_src1;
    else if (!ex_cancel && ex_valid && ex_op == 3'd4) m_lo = ex_src1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) if (chk_en) begin
    chk("ex_stall", ex_stall, is_div && !m_end);
    chk("div_begin", div_begin, m_pend && !m_end);
    chk("div_sign", div_sign, m_sign);
    chk("div_op1", div_op1, m_op1);
    chk("div_op2", div_op2, m_op2);
    chk("hi_out", hi_out, m_hi);
    chk("lo_out", lo_out, m_lo);
  end

  task automatic step(); @(posedge clk); #1; endtask
  task automatic idle(); ex_valid = 0; ex_op = 0; ex_cancel = 0; endtask
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    ex_valid = 1; ex_op = op; ex_src1 = a; ex_src2 = b;
  endtask
  // returns the number of stalled cycles; leaves the bench in the DONE cycle
  task automatic run_div(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, output int k);
    issue(op, a, b); #1; k = 0;
    while (ex_stall && k < 300) begin step(); k++; end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom % 5)
      0: return 0;
      1: return 32'h80000000;
      2: return 32'hFFFFFFFF;
      3: return $urandom % 64;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    step(); step(); resetn = 1; chk_en = 1;
    chk("rst hi", hi_out, 0); chk("rst lo", lo_out, 0);
    chk("rst begin", div_begin, 0); chk("rst stall", ex_stall, 0);
    run_div(3'd2, 100, 7, n); chk("stall cycles 100/7", n, 37);
    step(); idle(); chk("lo 100/7", lo_out, 14); chk("hi 100/7", hi_out, 2);
    run_div(3'd1, 32'hFFFFFFF9, 2, n); step(); idle();
    chk("lo -7/2", lo_out, 32'hFFFFFFFD); chk("hi -7/2", hi_out, 32'hFFFFFFFF);
    run_div(3'd1, 7, 32'hFFFFFFFE, n); step(); idle();
    chk("lo 7/-2", lo_out, 32'hFFFFFFFD); chk("hi 7/-2", hi_out, 1);
    run_div(3'd2, 32'hFFFFFFFF, 1, n); step();
    chk("lo ffffffff/1", lo_out, 32'hFFFFFFFF); chk("hi ffffffff/1", hi_out, 0);
    run_div(3'd2, 1000, 3, n); chk("back-to-back stall cycles", n, 37);
    step(); idle(); chk("lo 1000/3", lo_out, 333); chk("hi 1000/3", hi_out, 1);
    issue(3'd3, 32'h12345678, 0); #1; chk("mthi stall", ex_stall, 0);
    step(); chk("mthi hi", hi_out, 32'h12345678);
    issue(3'd4, 32'hCAFEBABE, 0); #1; chk("mtlo stall", ex_stall, 0);
    step(); idle(); chk("mtlo lo", lo_out, 32'hCAFEBABE);
    issue(3'd1, 50, 5);
    for (int i = 0; i < 10; i++) step();
    ex_cancel = 1; step(); idle();
    chk("cancel begin", div_begin, 0);
    chk("cancel hi", hi_out, 32'h12345678); chk("cancel lo", lo_out, 32'hCAFEBABE);
    run_div(3'd2, 9, 4, n); chk("after cancel stall cycles", n, 37);
    step(); idle(); chk("lo 9/4", lo_out, 2); chk("hi 9/4", hi_out, 1);
    issue(3'd2, 10, 3);
    for (int i = 0; i < 20; i++) step();
    resetn = 0; step(); resetn = 1; idle();
    chk("busy rst begin", div_begin, 0); chk("busy rst hi", hi_out, 0); chk("busy rst lo", lo_out, 0);
    run_div(3'd2, 10, 3, n); chk("after rst stall cycles", n, 37);
    step(); idle(); chk("lo 10/3", lo_out, 3); chk("hi 10/3", hi_out, 1);
    for (int c = 0; c < 5000; c++) begin
      @(negedge clk); hold = ex_stall && !ex_cancel;
      @(posedge clk); #1;
      ex_cancel = ($urandom % 20 == 0);
      resetn = ($urandom % 300 != 0);
      spur = ($urandom % 6 == 0) && (!m_pend || m_end);
      if (!hold) begin
        ex_valid = ($urandom % 4 != 0); ex_op = 3'($urandom % 6);
        ex_src1 = pick(); ex_src2 = pick(); lat = $urandom_range(1, 40);
      end
    end
    step(); idle(); spur = 0; resetn = 1;
    repeat (50) step();
    chk_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
